// File: rtl/line_buffer_ram.sv
// line_buffer_ram: multi-line pixel buffer for sliding-window filters.
// LINES-1 circular line memories hold the previous lines. Each accepted pixel
// produces a vertical column of LINES pixels one cycle later.

// One line memory: single write port, registered read port.
// A read and a write to the same address on the same edge return the old data.
module line_buffer_ram_mem #(
    parameter int DW    = 16,
    parameter int DEPTH = 640,
    parameter int AW    = 10
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // write port; contents survive reset and frame restart
    always_ff @(posedge i_clk) begin
        if (i_we) mem_q[i_addr] <= i_wdata;
    end

    // registered read, sees the pre-write contents
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)   rdata_q <= '0;
        else if (i_re) rdata_q <= mem_q[i_addr];
    end

    assign o_rdata = rdata_q;
endmodule

module line_buffer_ram #(
    parameter int DATA_WIDTH  = 16,
    parameter int LINE_LENGTH = 640,
    parameter int LINES       = 3
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_clear,
    input  logic                          i_valid,
    input  logic [DATA_WIDTH-1:0]         i_pixel,
    output logic                          o_valid,
    output logic [LINES*DATA_WIDTH-1:0]   o_column,
    output logic [$clog2(LINE_LENGTH)-1:0] o_col,
    output logic                          o_eol,
    output logic                          o_primed
);
    localparam int M     = LINES - 1;
    localparam int COLW  = $clog2(LINE_LENGTH);
    localparam int PTRW  = (M > 1) ? $clog2(M) : 1;
    localparam int FILLW = $clog2(LINES);

    logic [COLW-1:0]  col_q, col_d;
    logic [PTRW-1:0]  ptr_q, ptr_d;
    logic [FILLW-1:0] fill_q, fill_d;

    logic                  vld_q;
    logic [DATA_WIDTH-1:0] pix_q;
    logic [PTRW-1:0]       ptrc_q;
    logic [COLW-1:0]       ocol_q;
    logic                  eol_q;
    logic                  primed_q;

    logic [M-1:0][DATA_WIDTH-1:0]     rd;
    logic [LINES-1:0][DATA_WIDTH-1:0] column;

    logic accept, last_col;
    assign accept   = i_valid & ~i_clear;
    assign last_col = (col_q == COLW'(LINE_LENGTH - 1));

    // next-state for column counter, write pointer and filled-line count
    always_comb begin
        col_d  = col_q;
        ptr_d  = ptr_q;
        fill_d = fill_q;
        if (i_clear) begin
            col_d  = '0;
            ptr_d  = '0;
            fill_d = '0;
        end else if (i_valid) begin
            if (last_col) begin
                col_d  = '0;
                ptr_d  = (ptr_q == PTRW'(M - 1)) ? '0 : ptr_q + PTRW'(1);
                fill_d = (fill_q == FILLW'(M)) ? fill_q : fill_q + FILLW'(1);
            end else begin
                col_d = col_q + COLW'(1);
            end
        end
    end

    // state registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            col_q  <= '0;
            ptr_q  <= '0;
            fill_q <= '0;
        end else begin
            col_q  <= col_d;
            ptr_q  <= ptr_d;
            fill_q <= fill_d;
        end
    end

    // output pipeline: pointer captured at accept so muxing never uses live ptr
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vld_q    <= 1'b0;
            pix_q    <= '0;
            ptrc_q   <= '0;
            ocol_q   <= '0;
            eol_q    <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            vld_q <= accept;
            if (i_clear) begin
                primed_q <= 1'b0;
            end else if (accept) begin
                pix_q    <= i_pixel;
                ptrc_q   <= ptr_q;
                ocol_q   <= col_q;
                eol_q    <= last_col;
                primed_q <= (fill_q >= FILLW'(M));
            end
        end
    end

    // one memory per stored line; all read col, only the current line writes
    for (genvar m = 0; m < M; m++) begin : g_mem
        line_buffer_ram_mem #(
            .DW   (DATA_WIDTH),
            .DEPTH(LINE_LENGTH),
            .AW   (COLW)
        ) u_mem (
            .i_clk  (i_clk),
            .i_reset(i_reset),
            .i_we   (accept && (ptr_q == PTRW'(m))),
            .i_re   (accept),
            .i_addr (col_q),
            .i_wdata(i_pixel),
            .o_rdata(rd[m])
        );
    end

    // line k ago lives in memory (ptr-k) mod M, i.e. memory m when ptr == (m+k) mod M
    always_comb begin
        column    = '0;
        column[0] = pix_q;
        for (int k = 1; k <= M; k++) begin
            for (int m = 0; m < M; m++) begin
                if (ptrc_q == PTRW'((m + k) % M)) column[k] = rd[m];
            end
        end
    end

    assign o_valid  = vld_q;
    assign o_column = column;
    assign o_col    = ocol_q;
    assign o_eol    = eol_q;
    assign o_primed = primed_q;
endmodule

// File: tb/tb_line_buffer_ram.sv
// Scoreboard bench for line_buffer_ram: two instances (LINES=3/LL=4 and
// LINES=2/LL=3), directed raster sequences followed by random traffic.
module tb_line_buffer_ram;
    typedef struct packed {
        logic [2:0][7:0] sl;
        logic [2:0]      known;
        logic [1:0]      col;
        logic            eol;
        logic            primed;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       clr0, vld0, clr1, vld1;
    logic [7:0] pix0, pix1;
    logic        ov0, oe0, op0, ov1, oe1, op1;
    logic [23:0] ocolm0;
    logic [15:0] ocolm1;
    logic [1:0]  oc0, oc1;

    line_buffer_ram #(.DATA_WIDTH(8), .LINE_LENGTH(4), .LINES(3)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_clear(clr0), .i_valid(vld0), .i_pixel(pix0),
        .o_valid(ov0), .o_column(ocolm0), .o_col(oc0), .o_eol(oe0), .o_primed(op0));

    line_buffer_ram #(.DATA_WIDTH(8), .LINE_LENGTH(3), .LINES(2)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_clear(clr1), .i_valid(vld1), .i_pixel(pix1),
        .o_valid(ov1), .o_column(ocolm1), .o_col(oc1), .o_eol(oe1), .o_primed(op1));

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n [2];
    logic [7:0] img [2][8][4];
    exp_t q0[$];
    exp_t q1[$];
    exp_t last [2];

    task automatic cmp(input string name, input int d, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    function automatic exp_t zero_exp(input int d);
        exp_t z;
        z = '0;
        z.known = (d == 0) ? 3'b111 : 3'b011;
        return z;
    endfunction

    // reference: row/col from the count of accepted pixels since frame start,
    // slice k is the pixel k rows above, known only once that row exists
    task automatic model_accept(input int d, input logic [7:0] p, output exp_t e);
        int ll, m, r, c;
        ll = (d == 0) ? 4 : 3;
        m  = (d == 0) ? 2 : 1;
        r  = n[d] / ll;
        c  = n[d] % ll;
        img[d][r%8][c] = p;
        e = '0;
        e.sl[0] = p;
        e.known[0] = 1'b1;
        for (int k = 1; k <= m; k++) begin
            if (r >= k) begin
                e.sl[k] = img[d][(r-k)%8][c];
                e.known[k] = 1'b1;
            end
        end
        e.col    = 2'(c);
        e.eol    = (c == ll - 1);
        e.primed = (r >= m);
        n[d]++;
    endtask

    task automatic model_reset();
        n[0] = 0;
        n[1] = 0;
        q0.delete();
        q1.delete();
    endtask

    // issue one cycle of stimulus to dut d (other dut idles), then step to posedge+1
    task automatic drive(input int d, input logic v, input logic c, input logic [7:0] p);
        exp_t e;
        vld0 = 1'b0; clr0 = 1'b0; pix0 = '0;
        vld1 = 1'b0; clr1 = 1'b0; pix1 = '0;
        if (d == 0) begin vld0 = v; clr0 = c; pix0 = p; end
        else        begin vld1 = v; clr1 = c; pix1 = p; end
        if (c) n[d] = 0;
        else if (v) begin
            model_accept(d, p, e);
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input int d, input logic ov, input logic [23:0] cm,
                             input logic [1:0] oc, input logic oe, input logic op);
        exp_t e;
        bit   have;
        have = 1'b1;
        e = last[d];
        if (ov) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid dut%0d: got o_valid=1 expected 0 at %0t", d, $time);
                have = 1'b0;
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                last[d] = e;
            end
        end
        if (have) begin
            for (int k = 0; k < 3; k++)
                if (e.known[k]) cmp($sformatf("slice%0d", k), d, int'(cm[k*8 +: 8]), int'(e.sl[k]));
            cmp("o_col", d, int'(oc), int'(e.col));
            cmp("o_eol", d, int'(oe), int'(e.eol));
            cmp("o_primed", d, int'(op), int'(e.primed));
        end
    endtask

    task automatic check_zero();
        cmp("rst_valid", 0, int'(ov0), 0);
        cmp("rst_column", 0, int'(ocolm0), 0);
        cmp("rst_col", 0, int'(oc0), 0);
        cmp("rst_eol", 0, int'(oe0), 0);
        cmp("rst_primed", 0, int'(op0), 0);
        cmp("rst_valid", 1, int'(ov1), 0);
        cmp("rst_column", 1, int'(ocolm1), 0);
        cmp("rst_primed", 1, int'(op1), 0);
    endtask

    // idle-cycle expectation: reset zeroes everything, clear drops primed
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            last[0] = zero_exp(0);
            last[1] = zero_exp(1);
        end else begin
            if (clr0) last[0].primed = 1'b0;
            if (clr1) last[1].primed = 1'b0;
        end
    end

    // monitor
    always @(negedge clk) begin
        check_out(0, ov0, ocolm0, oc0, oe0, op0);
        check_out(1, ov1, {8'h00, ocolm1}, oc1, oe1, op1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stop;
        last[0] = zero_exp(0);
        last[1] = zero_exp(1);
        vld0 = 0; clr0 = 0; pix0 = 0; vld1 = 0; clr1 = 0; pix1 = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero();
        rst = 1'b0;

        // fill, pointer wrap, stall of 3 cycles after row 3 col 1
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 4; c++) begin
                drive(0, 1, 0, 8'(16*r + c));
                if (r == 3 && c == 1) repeat (3) drive(0, 0, 0, 8'h00);
            end
        repeat (2) drive(0, 0, 0, 8'h00);

        // new frame, then clear colliding with a valid pixel at row 3 col 2
        drive(0, 0, 1, 8'h00);
        stop = 1'b0;
        for (int r = 0; r < 4 && !stop; r++)
            for (int c = 0; c < 4 && !stop; c++) begin
                if (r == 3 && c == 2) begin
                    drive(0, 1, 1, 8'hAA);
                    stop = 1'b1;
                end else drive(0, 1, 0, 8'(16*r + c));
            end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++) drive(0, 1, 0, 8'(16*r + c));
        drive(0, 0, 0, 8'h00);

        // asynchronous reset mid-frame, between clock edges
        drive(0, 0, 1, 8'h00);
        for (int i = 0; i < 10; i++) drive(0, 1, 0, 8'(16*(i/4) + i%4));
        drive(0, 0, 0, 8'h00);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_zero();
        #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++) drive(0, 1, 0, 8'(16*r + c));
        drive(0, 0, 0, 8'h00);

        // two-line configuration
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) drive(1, 1, 0, 8'(16*r + c));
        drive(1, 0, 0, 8'h00);

        // random traffic on both instances
        for (int i = 0; i < 600; i++)
            drive(int'($urandom_range(0, 1)), ($urandom % 4) != 0,
                  ($urandom % 50) == 0, 8'($urandom));
        repeat (3) drive(0, 0, 0, 8'h00);

        cmp("q0_drained", 0, q0.size(), 0);
        cmp("q1_drained", 1, q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/line_buffer_ram.md
Name: line_buffer_ram

Overview:
- Parametrised multi-line pixel buffer for sliding-window filters (convolution, median, Sobel).
- Built from LINES-1 circular line memories. Each has one write port and one registered read port.
- Accepts a raster pixel stream and emits a vertical column of LINES pixels per accepted pixel: the current pixel plus the same column from each of the previous LINES-1 lines.
- Sits between the pixel source and the window/kernel stage.

Parameters:
- DATA_WIDTH, 16, bits per pixel.
- LINE_LENGTH, 640, pixels per line. Must be >= 2.
- LINES, 3, window height. Must be >= 2. Number of internal memories M = LINES-1.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_clear  input  1  synchronous frame restart (start of frame).
- i_valid  input  1  pixel strobe; i_pixel is accepted when high.
- i_pixel  input  DATA_WIDTH  incoming pixel, raster order.
- o_valid  output  1  o_column is valid this cycle.
- o_column  output  LINES*DATA_WIDTH  slice k (bits k*DATA_WIDTH +: DATA_WIDTH) is the pixel k lines above the current pixel; slice 0 is the current pixel.
- o_col  output  $clog2(LINE_LENGTH)  column index of the o_column data.
- o_eol  output  1  o_column is the last column of a line.
- o_primed  output  1  all LINES-1 upper slices hold real data from the current frame.

Behaviour:
- Reset (async assert) sets every output to 0: o_valid, o_column, o_col, o_eol, o_primed.
- Reset also clears the internal state: column counter col=0, write pointer ptr=0, filled-line count fill=0, all pipeline registers 0.
- Memory contents are not cleared by reset or by i_clear.
- Accept (i_valid=1, i_clear=0), all effects on the same edge:
  - Every memory m reads address col. Read data is registered, 1-cycle latency.
  - Memory ptr writes i_pixel at address col.
  - Read-before-write: memory ptr returns the old content (the line LINES-1 ago), never the new pixel.
- Line-age mapping: the memory written during the current line is ptr; the line k ago (k=1..M) resides in memory (ptr-k) mod M.
  - ptr and the mapping are captured into the pipeline at the accept edge.
  - Output muxing uses these registered values, never the live ptr.
- Output, one cycle after an accept:
  - o_valid=1.
  - Slice 0 = the accepted pixel, delayed one cycle.
  - Slice k = registered read of memory (ptr_captured-k) mod M.
  - o_col = col at accept.
  - o_eol = (col at accept == LINE_LENGTH-1).
- Column counter: increments on each accept; wraps LINE_LENGTH-1 -> 0.
- On wrap:
  - ptr advances by 1, wrapping M-1 -> 0.
  - fill increments, saturating at M.
- o_primed: registered alongside o_valid. It is 1 when fill >= M at the accept edge, i.e. before that edge's wrap update. Once set, it stays 1 until reset or i_clear.
- Stall (i_valid=0): no counter, pointer or memory change.
  - o_valid=0 next cycle.
  - o_column, o_col, o_eol and o_primed hold their last values.
- i_clear=1 at an edge:
  - col=0, ptr=0, fill=0.
  - o_valid=0 and o_primed=0 next cycle.
  - i_clear has priority over a coincident i_valid: that pixel is discarded and not written.
- Back-to-back accepts sustain 1 column per cycle. The block has no backpressure input.
- Reset asserted mid-line or mid-frame: immediate output clear. The next accept after release is column 0 of line 0.
- LINES=2 (M=1): the single memory is always ptr. Slice 1 is the same column of the previous line.

Test Plan:
- Fill sequence. Config DATA_WIDTH=8, LINE_LENGTH=4, LINES=3. Stream pixel=16*row+col, continuous i_valid.
  - Response: o_valid follows i_valid by 1 cycle.
  - o_primed=0 through the end of row 1. o_primed=1 from the output for row 2 col 0.
  - At row 2 col 1: o_column slices {0x21, 0x11, 0x01}, o_col=1, o_eol=0.
- Wrap and pointer rotation: same stream through row 5.
  - Row 4 col 3: slices {0x43, 0x33, 0x23}, o_eol=1.
  - Row 5 col 0: {0x50, 0x40, 0x30}. Confirms ptr wrap M-1 -> 0 with no corruption.
- Stall: insert 3 idle cycles mid-line 3 after col 1.
  - o_valid=0 for 3 cycles, and o_column holds {0x31, 0x21, 0x11}.
  - On resume, col 2 gives {0x32, 0x22, 0x12}.
- Clear priority: assert i_clear with i_valid=1 and pixel 0xAA at row 3 col 2.
  - Next cycle: o_valid=0, o_primed=0.
  - The next accepted pixel 0x00 is reported at o_col=0, and o_primed remains 0 for two full lines.
- Async reset mid-frame: pulse i_reset between clock edges at row 2 col 2.
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - After release, the first accept is reported with o_col=0, o_primed=0.
- LINES=2, LINE_LENGTH=3: stream rows 0-2.
  - Row 1 col 2 gives {0x12, 0x02}. Row 2 col 0 gives {0x20, 0x10}.
  - o_primed=1 from row 1 col 0 onward.
